// File: rtl/uart_load_sequencer_if.sv
// Handshake bundle between the UART byte streams, the CPU load port and the sequencer.
`timescale 1ns/1ps
interface uart_load_sequencer_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        cpu_done;
  logic [15:0] cpu_data;
  logic        cpu_reset;
  logic        uart_en;
  logic [15:0] uart_data;
  logic [1:0]  uart_sel;
  logic        busy;
  logic        err_overrun;

  modport master (
    input  rx_valid, rx_byte, tx_ready, cpu_done, cpu_data,
    output tx_valid, tx_byte, cpu_reset, uart_en, uart_data, uart_sel, busy, err_overrun
  );

  modport slave (
    output rx_valid, rx_byte, tx_ready, cpu_done, cpu_data,
    input  tx_valid, tx_byte, cpu_reset, uart_en, uart_data, uart_sel, busy, err_overrun
  );
endinterface

// File: rtl/uart_load_sequencer.sv
// Byte command sequencer: loads CPU memories/registers from UART, runs the CPU and reports the result.
`timescale 1ns/1ps
module uart_load_sequencer #(
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned CNT_W    = 20,
  parameter logic [7:0]  ACK_BYTE = 8'h4B
) (
  input  logic clk,
  input  logic reset,
  uart_load_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, GET_LEN, GET_HI, GET_LO, WRITE, ACK, RUN, TX_STAT, TX_HI, TX_LO
  } state_e;

  state_e           state_q;
  logic [8:0]       cnt_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [15:0]      result_q;
  logic             tx_valid_q;
  logic [7:0]       tx_byte_q;
  logic             cpu_reset_q;
  logic             uart_en_q;
  logic [15:0]      uart_data_q;
  logic [1:0]       uart_sel_q;
  logic             busy_q;
  logic             err_overrun_q;
  logic             accepting;

  assign accepting = (state_q == IDLE) || (state_q == GET_LEN) ||
                     (state_q == GET_HI) || (state_q == GET_LO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      run_cnt_q     <= '0;
      result_q      <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= '0;
      cpu_reset_q   <= 1'b1;
      uart_en_q     <= 1'b0;
      uart_data_q   <= '0;
      uart_sel_q    <= '0;
      busy_q        <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      uart_en_q <= 1'b0;
      if (bus.rx_valid && !accepting) err_overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // Commands with any of bits[7:2] set are silently ignored.
          if (bus.rx_valid && (bus.rx_byte[7:2] == '0)) begin
            busy_q <= 1'b1;
            if (bus.rx_byte[1:0] == 2'd3) begin
              run_cnt_q   <= '0;
              cpu_reset_q <= 1'b0;
              state_q     <= RUN;
            end else begin
              uart_sel_q <= bus.rx_byte[1:0];
              state_q    <= GET_LEN;
            end
          end
        end
        GET_LEN: if (bus.rx_valid) begin
          cnt_q   <= (bus.rx_byte == '0) ? 9'd256 : {1'b0, bus.rx_byte};
          state_q <= GET_HI;
        end
        GET_HI: if (bus.rx_valid) begin
          uart_data_q[15:8] <= bus.rx_byte;
          state_q           <= GET_LO;
        end
        GET_LO: if (bus.rx_valid) begin
          uart_data_q[7:0] <= bus.rx_byte;
          uart_en_q        <= 1'b1;
          state_q          <= WRITE;
        end
        WRITE: begin
          cnt_q <= cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            tx_valid_q <= 1'b1;
            tx_byte_q  <= ACK_BYTE;
            state_q    <= ACK;
          end else begin
            state_q <= GET_HI;
          end
        end
        ACK: if (bus.tx_ready) begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        RUN: begin
          run_cnt_q <= run_cnt_q + CNT_W'(1);
          // Done takes priority over a coincident timeout.
          if (bus.cpu_done || (run_cnt_q == CNT_W'(TIMEOUT - 1))) begin
            result_q    <= bus.cpu_data;
            tx_valid_q  <= 1'b1;
            tx_byte_q   <= bus.cpu_done ? 8'h00 : 8'hFF;
            cpu_reset_q <= 1'b1;
            state_q     <= TX_STAT;
          end
        end
        TX_STAT: if (bus.tx_ready) begin
          tx_byte_q <= result_q[15:8];
          state_q   <= TX_HI;
        end
        TX_HI: if (bus.tx_ready) begin
          tx_byte_q <= result_q[7:0];
          state_q   <= TX_LO;
        end
        TX_LO: if (bus.tx_ready) begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.uart_en     = uart_en_q;
  assign bus.uart_data   = uart_data_q;
  assign bus.uart_sel    = uart_sel_q;
  assign bus.busy        = busy_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_load_sequencer.sv
// Directed + randomized bench for uart_load_sequencer with a queue-based expectation model.
`timescale 1ns/1ps
module tb_uart_load_sequencer;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic reset;
  logic tx_auto = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [17:0] obs_wr[$];
  logic [17:0] exp_wr[$];
  logic [7:0]  obs_tx[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] wq[$];

  uart_load_sequencer_if bus();

  uart_load_sequencer #(.TIMEOUT(TO), .CNT_W(8), .ACK_BYTE(8'h4B)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bus.tx_ready = tx_auto ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  always @(negedge clk) begin
    if (bus.uart_en === 1'b1) obs_wr.push_back({bus.uart_sel, bus.uart_data});
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) obs_tx.push_back(bus.tx_byte);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Sends a load block for the words in wq and records what the CPU port and TX must show.
  task automatic load(input logic [1:0] sel);
    int n;
    n = wq.size();
    send_byte({6'b0, sel});
    idle($urandom_range(0, 2));
    send_byte((n == 256) ? 8'h00 : 8'(n));
    foreach (wq[i]) begin
      idle($urandom_range(0, 2));
      send_byte(wq[i][15:8]);
      idle($urandom_range(0, 1));
      send_byte(wq[i][7:0]);
      exp_wr.push_back({sel, wq[i]});
      tick();
    end
    exp_tx.push_back(8'h4B);
    wq.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && bus.busy === 1'b1; i++) tick();
    chk("busy_low", bus.busy, 0);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      chk({tag, "_wr"}, obs_wr[i], exp_wr[i]);
    chk({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      chk({tag, "_tx"}, obs_tx[i], exp_tx[i]);
    obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_valid"},  bus.tx_valid,    0);
    chk({tag, "_tx_byte"},   bus.tx_byte,     0);
    chk({tag, "_cpu_reset"}, bus.cpu_reset,   1);
    chk({tag, "_uart_en"},   bus.uart_en,     0);
    chk({tag, "_uart_data"}, bus.uart_data,   0);
    chk({tag, "_uart_sel"},  bus.uart_sel,    0);
    chk({tag, "_busy"},      bus.busy,        0);
    chk({tag, "_overrun"},   bus.err_overrun, 0);
  endtask

  // cpu_done rises d cycles into RUN; cpu_data = base + cycle index so the capture cycle is visible.
  task automatic run_case(input int d, input logic [15:0] base);
    int kexit;
    logic [15:0] res;
    kexit = (d < int'(TO)) ? d : int'(TO) - 1;
    res   = base + 16'(kexit);
    send_byte(8'h03);
    for (int k = 0; k <= kexit + 1; k++) begin
      chk("run_cpu_reset", bus.cpu_reset, (k <= kexit) ? 0 : 1);
      bus.cpu_data = base + 16'(k);
      bus.cpu_done = (k >= d);
      tick();
    end
    bus.cpu_done = 1'b0;
    exp_tx.push_back((d < int'(TO)) ? 8'h00 : 8'hFF);
    exp_tx.push_back(res[15:8]);
    exp_tx.push_back(res[7:0]);
    wait_idle();
    chk("run_cpu_reset_after", bus.cpu_reset, 1);
    compare("run");
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;
    bus.cpu_done = 1'b0;
    bus.cpu_data = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;
    tick();
    tx_auto = 1'b1;

    wq.push_back(16'h1234);
    wq.push_back(16'hABCD);
    load(2'd0);
    wait_idle();
    compare("two_words");

    repeat (256) wq.push_back(16'($urandom));
    load(2'd2);
    wait_idle();
    compare("len0");

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 5)) wq.push_back(16'($urandom));
      load(2'($urandom_range(0, 2)));
      wait_idle();
      compare("rand_load");
    end

    run_case(10, 16'hBEEF - 16'd10);
    run_case(0, 16'($urandom));
    run_case(100, 16'($urandom));
    run_case(int'(TO) - 1, 16'($urandom));
    run_case(int'(TO), 16'($urandom));

    tx_auto = 1'b0;
    wq.push_back(16'($urandom));
    load(2'd1);
    for (int i = 0; i < 20 && bus.tx_valid !== 1'b1; i++) tick();
    chk("ack_valid", bus.tx_valid, 1);
    chk("overrun_pre", bus.err_overrun, 0);
    send_byte(8'h55);
    chk("overrun_set", bus.err_overrun, 1);
    chk("ack_held_valid", bus.tx_valid, 1);
    chk("ack_held_byte", bus.tx_byte, 8'h4B);
    tx_auto = 1'b1;
    wait_idle();
    compare("overrun");

    send_byte(8'h84);
    chk("badcmd_busy", bus.busy, 0);
    idle(3);
    chk("badcmd_busy_later", bus.busy, 0);
    chk("overrun_sticky", bus.err_overrun, 1);
    compare("badcmd");

    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hAA);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    reset = 1'b1;
    tick();
    wq.push_back(16'h0007);
    load(2'd1);
    wait_idle();
    compare("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
